// File: rtl/pre_if_stage_pkg.sv
// Shared definitions for the pre-IF stage: reset PC, bus widths, bus bit
// offsets and small helpers for fetch-address formation.
package pre_if_stage_pkg;

   localparam logic [31:0] PREIF_RESET_PC = 32'hBFC0_0000;

   localparam int PC_W                 = 32;
   localparam int PRED_COMPUTEPC_BUS_W = 33;
   localparam int PREIF_IF_BUS_W       = 33;
   localparam int PREIF_PRED_BUS_W     = 67;

   // predictor_computepc_bus_i fields
   localparam int PCB_DATA2    = 0;
   localparam int PCB_ADDR_LSB = 1;

   // preif_preditor_bus_o fields
   localparam int PPB_DATA2      = 0;
   localparam int PPB_PC_LSB     = 1;
   localparam int PPB_FIRE       = 33;
   localparam int PPB_TO_VALID   = 34;
   localparam int PPB_TO_PC_LSB  = 35;

   // Where the next fetch-group PC comes from in a given cycle.
   typedef enum logic [1:0] {
      PC_SRC_HOLD     = 2'd0,
      PC_SRC_REDIRECT = 2'd1,
      PC_SRC_PEND     = 2'd2,
      PC_SRC_PRED     = 2'd3
   } pc_src_e;

   // A group fetches two words only when it starts on an 8-byte boundary
   // and the source allows it.
   function automatic logic data2_of(input logic allow, input logic addr_bit2);
      return allow & ~addr_bit2;
   endfunction

   // Two-word groups are requested from the aligned double-word address.
   function automatic logic [31:0] fetch_addr(input logic [31:0] pc, input logic data2);
      return data2 ? {pc[31:3], 3'b000} : pc;
   endfunction

endpackage

// File: rtl/preif_redirect_buf.sv
// Redirect arbitration and buffering: picks exception over branch and
// parks a redirect that arrives while an I-cache request is mid-handshake,
// so the outstanding address can finish before the PC moves.
module preif_redirect_buf
   import pre_if_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              exception_flag_i,
   input  logic [PC_W-1:0]   exception_addr_i,
   input  logic              branch_flag_i,
   input  logic [PC_W-1:0]   branch_addr_i,
   input  logic              req_stall_i,
   input  logic              req_accept_i,
   output logic              redirect_o,
   output logic [PC_W-1:0]   target_o,
   output logic              cxl_o,
   output logic              pend_v_o,
   output logic [PC_W-1:0]   pend_addr_o
);

   logic            cxl_q, cxl_d;
   logic            pend_v_q, pend_v_d;
   logic [PC_W-1:0] pend_addr_q, pend_addr_d;
   logic            capture;

   assign redirect_o = exception_flag_i | branch_flag_i;
   assign target_o   = exception_flag_i ? exception_addr_i : branch_addr_i;
   assign capture    = redirect_o & req_stall_i;

   // Newest redirect overwrites the parked target; the accepted address clears it.
   always_comb begin
      cxl_d       = cxl_q;
      pend_v_d    = pend_v_q;
      pend_addr_d = pend_addr_q;
      if (capture) begin
         cxl_d       = 1'b1;
         pend_v_d    = 1'b1;
         pend_addr_d = target_o;
      end else if (req_accept_i) begin
         cxl_d    = 1'b0;
         pend_v_d = 1'b0;
      end
   end

   // Parked-redirect state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cxl_q       <= 1'b0;
         pend_v_q    <= 1'b0;
         pend_addr_q <= '0;
      end else begin
         cxl_q       <= cxl_d;
         pend_v_q    <= pend_v_d;
         pend_addr_q <= pend_addr_d;
      end
   end

   assign cxl_o       = cxl_q;
   assign pend_v_o    = pend_v_q;
   assign pend_addr_o = pend_addr_q;

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: holds the fetch-group PC, selects the next PC
// (exception > branch correction > predictor), issues the I-cache address
// request and hands accepted groups to IF.
module pre_if_stage
   import pre_if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = PREIF_RESET_PC
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            exception_flag_i,
   input  logic [PC_W-1:0]                 exception_addr_i,
   input  logic                            branch_flag_i,
   input  logic [PC_W-1:0]                 branch_addr_i,
   input  logic [PRED_COMPUTEPC_BUS_W-1:0] predictor_computepc_bus_i,
   input  logic                            if_allowin_i,
   output logic                            inst_req_o,
   output logic [PC_W-1:0]                 inst_addr_o,
   input  logic                            inst_addr_ok_i,
   output logic                            inst_discard_o,
   output logic                            preif_to_if_valid_o,
   output logic [PREIF_IF_BUS_W-1:0]       preif_if_bus_o,
   output logic [PREIF_PRED_BUS_W-1:0]     preif_preditor_bus_o
);

   // Handshakes: an address transfer to the I-cache happens in a cycle with
   // inst_req_o & inst_addr_ok_i, and inst_req_o/inst_addr_o hold steady until
   // it does. A group transfer to IF (fire) happens in a cycle with
   // preif_to_if_valid_o & if_allowin_i; preif_to_if_valid_o holds until fire
   // unless a redirect cancels the group.

   logic [PC_W-1:0] pc_q, pc_d;
   logic            data2_q, data2_d;
   logic            valid_q, valid_d;
   logic            acc_q, acc_d;

   logic            redirect;
   logic [PC_W-1:0] redirect_target;
   logic            cxl;
   logic            pend_v;
   logic [PC_W-1:0] pend_addr;

   logic            inst_req, accept, stall, ready_go, to_if_valid, fire;
   logic            discard, pc_load;
   logic [PC_W-1:0] pred_next_addr;
   logic            pred_data2;
   pc_src_e         pc_src;

   assign pred_next_addr = predictor_computepc_bus_i[PCB_ADDR_LSB +: PC_W];
   assign pred_data2     = predictor_computepc_bus_i[PCB_DATA2];

   assign inst_req    = valid_q & ~acc_q;
   assign accept      = inst_req & inst_addr_ok_i;
   assign stall       = inst_req & ~inst_addr_ok_i;
   assign ready_go    = acc_q | accept;
   assign to_if_valid = valid_q & ready_go & ~cxl & ~redirect;
   assign fire        = to_if_valid & if_allowin_i;

   preif_redirect_buf u_redirect_buf (
      .clk              (clk),
      .rst_n            (rst_n),
      .exception_flag_i (exception_flag_i),
      .exception_addr_i (exception_addr_i),
      .branch_flag_i    (branch_flag_i),
      .branch_addr_i    (branch_addr_i),
      .req_stall_i      (stall),
      .req_accept_i     (accept),
      .redirect_o       (redirect),
      .target_o         (redirect_target),
      .cxl_o            (cxl),
      .pend_v_o         (pend_v),
      .pend_addr_o      (pend_addr)
   );

   // Choose the PC source and the next group state; a stalled request keeps
   // the PC until the cache takes the address, then the parked target loads.
   always_comb begin
      pc_src  = PC_SRC_HOLD;
      discard = 1'b0;
      pc_d    = pc_q;
      data2_d = data2_q;
      valid_d = valid_q;
      acc_d   = acc_q;

      if (redirect && !stall) begin
         pc_src  = PC_SRC_REDIRECT;
         discard = acc_q | accept;
      end else if (redirect) begin
         pc_src = PC_SRC_HOLD;
      end else if (pend_v && accept) begin
         pc_src  = PC_SRC_PEND;
         discard = 1'b1;
      end else if (fire) begin
         pc_src = PC_SRC_PRED;
      end else if (ready_go && !if_allowin_i) begin
         acc_d = 1'b1;
      end else if (!valid_q) begin
         valid_d = 1'b1;
      end

      case (pc_src)
         PC_SRC_REDIRECT: begin
            pc_d    = redirect_target;
            data2_d = data2_of(1'b1, redirect_target[2]);
            valid_d = 1'b1;
            acc_d   = 1'b0;
         end
         PC_SRC_PEND: begin
            pc_d    = pend_addr;
            data2_d = data2_of(1'b1, pend_addr[2]);
            acc_d   = 1'b0;
         end
         PC_SRC_PRED: begin
            pc_d    = pred_next_addr;
            data2_d = data2_of(pred_data2, pred_next_addr[2]);
            acc_d   = 1'b0;
         end
         default: begin
         end
      endcase

      pc_load = (pc_src != PC_SRC_HOLD);
   end

   // Fetch-group state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         data2_q <= ~RESET_PC[2];
         valid_q <= 1'b0;
         acc_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         data2_q <= data2_d;
         valid_q <= valid_d;
         acc_q   <= acc_d;
      end
   end

   assign inst_req_o          = inst_req;
   assign inst_addr_o         = fetch_addr(pc_q, data2_q);
   assign inst_discard_o      = discard;
   assign preif_to_if_valid_o = to_if_valid;
   assign preif_if_bus_o      = {pc_q, data2_q};
   assign preif_preditor_bus_o = {pc_d, pc_load, fire, pc_q, data2_q};

endmodule
